vga_pixel_fetch: RTL and testbench

VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

---
 rtl/vga_pixel_fetch_pkg.sv | 45 ++++
 rtl/vga_delay_line.sv | 27 ++
 rtl/vga_pixel_fetch.sv | 118 +++++++++++
 tb/tb_vga_pixel_fetch.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pixel_fetch_pkg.sv
// Shared constants and types for the VGA scan-out path: framebuffer geometry,
// pipeline depth and RGB332 field layout used by sync consumers and the GPU write side.
package vga_pixel_fetch_pkg;

   localparam int FB_W_DEF     = 160;
   localparam int FB_H_DEF     = 120;
   localparam int SCALE_SH_DEF = 2;
   localparam int PIPE_DEPTH   = 3;
   localparam int ADDR_W       = 16;

   // RGB332 field positions within a framebuffer byte
   localparam int R_HI = 7;
   localparam int R_LO = 5;
   localparam int G_HI = 4;
   localparam int G_LO = 2;
   localparam int B_HI = 1;
   localparam int B_LO = 0;

   typedef struct packed {
      logic h_sync;
      logic v_sync;
      logic blank_n;
   } sync_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef enum logic {
      SW_ARMED = 1'b0,
      SW_HOLD  = 1'b1
   } swap_st_t;

   // Replicate the high bits downward so full-scale codes reach 0xFF.
   function automatic rgb_t rgb332_expand(input logic [7:0] p);
      rgb_t c;
      c.r = {p[R_HI:R_LO], p[R_HI:R_LO], p[R_HI:R_HI-1]};
      c.g = {p[G_HI:G_LO], p[G_HI:G_LO], p[G_HI:G_HI-1]};
      c.b = {4{p[B_HI:B_LO]}};
      return c;
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with a programmable reset value; keeps sync and
// blank coherent with the colour pipeline.
module vga_delay_line #(
   parameter int             W       = 1,
   parameter int             DEPTH   = 3,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [DEPTH-1:0][W-1:0] sr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr <= {DEPTH{RST_VAL}};
      end else begin
         sr[0] <= din;
         for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
   end

   assign dout = sr[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// Scan-out fetch: maps screen coordinates to a double-buffered framebuffer,
// expands RGB332 to 8:8:8 and swaps buffers only at vertical sync start.
module vga_pixel_fetch
   import vga_pixel_fetch_pkg::*;
#(
   parameter int FB_W     = FB_W_DEF,
   parameter int FB_H     = FB_H_DEF,
   parameter int SCALE_SH = SCALE_SH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              h_sync,
   input  logic              v_sync,
   input  logic              blank_n,
   input  logic [9:0]        pos_x,
   input  logic [9:0]        pos_y,
   output logic [ADDR_W-1:0] fb_addr,
   input  logic [7:0]        fb_rdata,
   input  logic              swap_req,
   output logic              swap_ack,
   output logic [7:0]        vga_r,
   output logic [7:0]        vga_g,
   output logic [7:0]        vga_b,
   output logic              h_sync_o,
   output logic              v_sync_o,
   output logic              blank_n_o
);

   localparam logic [ADDR_W-1:0] BACK_BASE = ADDR_W'(FB_W * FB_H);
   localparam sync_t SYNC_IDLE = '{h_sync: 1'b1, v_sync: 1'b1, blank_n: 1'b0};

   logic              front;
   logic              vs_prev;
   logic              vs_start;
   logic              do_swap;
   swap_st_t          sw_st;
   swap_st_t          sw_nxt;
   logic [ADDR_W-1:0] fb_x;
   logic [ADDR_W-1:0] fb_y;
   logic [ADDR_W-1:0] addr_nxt;
   logic [7:0]        pix_q;
   rgb_t              rgb_q;
   sync_t             sync_in;
   sync_t             sync_out;

   assign vs_start = vs_prev & ~v_sync;

   // Swap handshake: one swap per request; a request must drop before re-arming.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sw_st <= SW_ARMED;
      else      sw_st <= sw_nxt;
   end

   always_comb begin
      sw_nxt = sw_st;
      case (sw_st)
         SW_ARMED: if (vs_start && swap_req) sw_nxt = SW_HOLD;
         SW_HOLD:  if (!swap_req)            sw_nxt = SW_ARMED;
         default:                            sw_nxt = SW_ARMED;
      endcase
   end

   always_comb begin
      do_swap = (sw_st == SW_ARMED) && vs_start && swap_req;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vs_prev  <= 1'b1;
         front    <= 1'b0;
         swap_ack <= 1'b0;
      end else begin
         vs_prev  <= v_sync;
         front    <= front ^ do_swap;
         swap_ack <= do_swap;
      end
   end

   assign fb_x     = ADDR_W'(pos_x >> SCALE_SH);
   assign fb_y     = ADDR_W'(pos_y >> SCALE_SH);
   assign addr_nxt = (front ? BACK_BASE : '0) + fb_y * ADDR_W'(FB_W) + fb_x;

   // S0 address, S1 read data for the address issued one edge earlier, S2 colour.
   // Address holds through blanking so off-screen coordinates never reach memory.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fb_addr <= '0;
         pix_q   <= '0;
         rgb_q   <= '0;
      end else begin
         if (blank_n) fb_addr <= addr_nxt;
         pix_q <= fb_rdata;
         rgb_q <= rgb332_expand(pix_q);
      end
   end

   assign sync_in = '{h_sync: h_sync, v_sync: v_sync, blank_n: blank_n};

   vga_delay_line #(
      .W       ($bits(sync_t)),
      .DEPTH   (PIPE_DEPTH),
      .RST_VAL (SYNC_IDLE)
   ) u_sync_dly (
      .clk   (clk),
      .rst_n (rst),
      .din   (sync_in),
      .dout  (sync_out)
   );

   assign h_sync_o  = sync_out.h_sync;
   assign v_sync_o  = sync_out.v_sync;
   assign blank_n_o = sync_out.blank_n;

   assign vga_r = blank_n_o ? rgb_q.r : 8'h00;
   assign vga_g = blank_n_o ? rgb_q.g : 8'h00;
   assign vga_b = blank_n_o ? rgb_q.b : 8'h00;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Scoreboard bench for vga_pixel_fetch: stimulus pushes expectations computed
// from screen-to-framebuffer arithmetic; a negedge monitor pops and compares.
module tb_vga_pixel_fetch;

   localparam int FB_W = 160;
   localparam int FB_H = 120;

   logic        clk      = 1'b0;
   logic        rst      = 1'b0;
   logic        h_sync   = 1'b1;
   logic        v_sync   = 1'b1;
   logic        blank_n  = 1'b0;
   logic        swap_req = 1'b0;
   logic [9:0]  pos_x    = '0;
   logic [9:0]  pos_y    = '0;
   logic [15:0] fb_addr;
   logic [7:0]  fb_rdata;
   logic        swap_ack;
   logic [7:0]  vga_r, vga_g, vga_b;
   logic        h_sync_o, v_sync_o, blank_n_o;

   logic [7:0]  mem [65536];

   int cyc    = 0;
   int errors = 0;
   int checks = 0;

   typedef struct { int due; logic [15:0] addr; logic ack; } aexp_t;
   typedef struct { int due; logic h; logic v; logic b; logic [7:0] r; logic [7:0] g; logic [7:0] bl; } pexp_t;
   aexp_t qa[$];
   pexp_t qp[$];

   // reference state: which buffer is displayed, whether a new request may swap
   logic        front_m, armed_m, vprev_m, req_now;
   logic [15:0] addr_m;

   vga_pixel_fetch #(.FB_W(FB_W), .FB_H(FB_H), .SCALE_SH(2)) dut (
      .clk(clk), .rst(rst), .h_sync(h_sync), .v_sync(v_sync), .blank_n(blank_n),
      .pos_x(pos_x), .pos_y(pos_y), .fb_addr(fb_addr), .fb_rdata(fb_rdata),
      .swap_req(swap_req), .swap_ack(swap_ack),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .h_sync_o(h_sync_o), .v_sync_o(v_sync_o), .blank_n_o(blank_n_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign fb_rdata = mem[fb_addr];

   function automatic logic [7:0] exp_r(input logic [7:0] p);
      int c;
      c = int'(p) / 32;
      return 8'(c * 32 + c * 4 + c / 2);
   endfunction

   function automatic logic [7:0] exp_g(input logic [7:0] p);
      int c;
      c = (int'(p) / 4) % 8;
      return 8'(c * 32 + c * 4 + c / 2);
   endfunction

   function automatic logic [7:0] exp_b(input logic [7:0] p);
      return 8'((int'(p) % 4) * 85);
   endfunction

   task automatic chk(input string nm, input int act, input int expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   task automatic model_step(input logic h, input logic v, input logic b,
                             input logic [9:0] x, input logic [9:0] y, input logic req);
      logic       vs, sw;
      logic [7:0] p;
      vs = vprev_m && !v;
      sw = vs && req && armed_m;
      if (b) addr_m = 16'((front_m ? FB_W * FB_H : 0) + (int'(y) / 4) * FB_W + int'(x) / 4);
      p = mem[addr_m];
      qa.push_back('{cyc + 1, addr_m, sw});
      qp.push_back('{cyc + 3, h, v, b, b ? exp_r(p) : 8'h00, b ? exp_g(p) : 8'h00, b ? exp_b(p) : 8'h00});
      if (sw) begin
         front_m = ~front_m;
         armed_m = 1'b0;
      end else if (!req) begin
         armed_m = 1'b1;
      end
      vprev_m = v;
   endtask

   task automatic drive(input logic h, input logic v, input logic b,
                        input logic [9:0] x, input logic [9:0] y);
      @(posedge clk);
      #1;
      h_sync = h; v_sync = v; blank_n = b; pos_x = x; pos_y = y; swap_req = req_now;
      model_step(h, v, b, x, y, req_now);
   endtask

   task automatic do_reset(input int hold);
      @(posedge clk);
      #1;
      rst = 1'b0;
      h_sync = 1'b1; v_sync = 1'b1; blank_n = 1'b0; swap_req = 1'b0; req_now = 1'b0;
      qa.delete();
      qp.delete();
      #1;
      chk("rst_fb_addr", int'(fb_addr), 0);
      chk("rst_swap_ack", int'(swap_ack), 0);
      chk("rst_rgb", int'({vga_r, vga_g, vga_b}), 0);
      chk("rst_h_sync_o", int'(h_sync_o), 1);
      chk("rst_v_sync_o", int'(v_sync_o), 1);
      chk("rst_blank_n_o", int'(blank_n_o), 0);
      repeat (hold) @(posedge clk);
      #1;
      rst = 1'b1;
      front_m = 1'b0; armed_m = 1'b1; vprev_m = 1'b1; addr_m = 16'h0;
      qa.push_back('{cyc, 16'h0, 1'b0});
      for (int i = 0; i < 3; i++) qp.push_back('{cyc + i, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00});
      model_step(1'b1, 1'b1, 1'b0, pos_x, pos_y, 1'b0);
   endtask

   task automatic step_req(input bit rnd);
      if (rnd && $urandom_range(0, 9) == 0) req_now = ~req_now;
   endtask

   // compressed frame: visible pixels, horizontal blank, vsync pulse, back porch
   task automatic frame(input int nvis, input logic ra, input logic rb, input bit rnd);
      if (!rnd) req_now = ra;
      for (int i = 0; i < nvis; i++) begin
         if (!rnd && i == nvis / 2) req_now = rb;
         step_req(rnd);
         drive(1'($urandom), 1'b1, 1'b1, 10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)));
      end
      for (int i = 0; i < 4; i++) begin
         step_req(rnd);
         drive(1'($urandom), 1'b1, 1'b0, 10'($urandom), 10'($urandom));
      end
      for (int i = 0; i < 3; i++) begin
         step_req(rnd);
         drive(1'b1, 1'b0, 1'b0, 10'($urandom), 10'($urandom));
      end
      for (int i = 0; i < 2; i++) begin
         step_req(rnd);
         drive(1'b1, 1'b1, 1'b0, 10'($urandom), 10'($urandom));
      end
   endtask

   initial begin : monitor
      aexp_t ea;
      pexp_t ep;
      forever begin
         @(negedge clk);
         if (qa.size() > 0 && qa[0].due == cyc) begin
            ea = qa.pop_front();
            chk("fb_addr", int'(fb_addr), int'(ea.addr));
            chk("swap_ack", int'(swap_ack), int'(ea.ack));
         end
         if (qp.size() > 0 && qp[0].due == cyc) begin
            ep = qp.pop_front();
            chk("h_sync_o", int'(h_sync_o), int'(ep.h));
            chk("v_sync_o", int'(v_sync_o), int'(ep.v));
            chk("blank_n_o", int'(blank_n_o), int'(ep.b));
            chk("vga_r", int'(vga_r), int'(ep.r));
            chk("vga_g", int'(vga_g), int'(ep.g));
            chk("vga_b", int'(vga_b), int'(ep.bl));
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: bench did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      mem[0] = 8'hE0;
      req_now = 1'b0;
      do_reset(2);

      // pixel mapping corners and pure-red colour on front buffer
      drive(1'b1, 1'b1, 1'b1, 10'd0, 10'd0);
      drive(1'b1, 1'b1, 1'b1, 10'd3, 10'd3);
      drive(1'b1, 1'b1, 1'b1, 10'd4, 10'd0);
      drive(1'b1, 1'b1, 1'b1, 10'd639, 10'd479);
      drive(1'b1, 1'b1, 1'b0, 10'd1000, 10'd900);
      drive(1'b1, 1'b1, 1'b0, 10'd0, 10'd0);
      drive(1'b1, 1'b1, 1'b1, 10'd0, 10'd0);
      frame(8, 1'b0, 1'b0, 1'b0);

      // mid-frame request swaps at the next vsync start
      frame(20, 1'b0, 1'b1, 1'b0);
      req_now = 1'b0;
      drive(1'b1, 1'b1, 1'b1, 10'd0, 10'd0);
      frame(10, 1'b0, 1'b0, 1'b0);

      // request held across three frames swaps once
      frame(10, 1'b1, 1'b1, 1'b0);
      frame(10, 1'b1, 1'b1, 1'b0);
      frame(10, 1'b1, 1'b1, 1'b0);
      frame(6, 1'b0, 1'b0, 1'b0);

      // back buffer shown, then reset mid-line
      frame(10, 1'b0, 1'b1, 1'b0);
      req_now = 1'b0;
      for (int i = 0; i < 5; i++)
         drive(1'b1, 1'b1, 1'b1, 10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)));
      do_reset(3);
      drive(1'b1, 1'b1, 1'b1, 10'd0, 10'd0);
      frame(10, 1'b0, 1'b0, 1'b0);

      for (int f = 0; f < 15; f++) frame($urandom_range(5, 30), 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 10'd0, 10'd0);

      repeat (5) @(negedge clk);
      #1;
      chk("scoreboard_drained", qa.size() + qp.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
